// File: rtl/cond_sink_src.sv
// rtl/cond_sink_src.sv - clocked token FIFO issuing 4-phase bundled-data transfers to a conditional sink
// Optional feature macro: COND_SINK_SRC_CNT_EN adds cnt_pass/cnt_drop completion counters.
module cond_sink_src #(
    parameter int N     = 32'd1,
    parameter int DEPTH = 32'd2,
    parameter int SYNC  = 32'd2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    input  logic         s_keep,
    output logic         r_o,
    input  logic         a_o,
    output logic [N-1:0] d_o,
    output logic         rctl_o,
    output logic         dctl_o,
    input  logic         actl_o
`ifdef COND_SINK_SRC_CNT_EN
    ,
    output logic [31:0]  cnt_pass,
    output logic [31:0]  cnt_drop
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] REQ  = 2'd2;
    localparam logic [1:0] RTZ  = 2'd3;

    logic [1:0]      state;
    logic [N:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [SYNC-1:0] a_sync;
    logic [SYNC-1:0] actl_sync;
    logic            a_s;
    logic            actl_s;
    logic            acks_high;
    logic            acks_low;
    logic            push;
    logic            pop;
    logic [N:0]      head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign a_s       = a_sync[SYNC-1];
    assign actl_s    = actl_sync[SYNC-1];
    assign acks_high = a_s & actl_s;
    assign acks_low  = !a_s & !actl_s;
    assign push      = s_valid & s_ready;
    // The head is popped on the edge that enters LOAD, so d_o/dctl_o lead the request by a clock.
    assign pop       = (count != '0) && ((state == IDLE) || ((state == RTZ) && acks_low));
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_keep, s_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            s_ready   <= 1'b0;
            a_sync    <= '0;
            actl_sync <= '0;
            r_o       <= 1'b0;
            rctl_o    <= 1'b0;
            d_o       <= '0;
            dctl_o    <= 1'b0;
        end else begin
            a_sync    <= {a_sync[SYNC-2:0], a_o};
            actl_sync <= {actl_sync[SYNC-2:0], actl_o};
            count     <= count_nxt;
            s_ready   <= (count_nxt != CW'(DEPTH));
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                d_o    <= head[N-1:0];
                dctl_o <= head[N];
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    r_o    <= 1'b1;
                    rctl_o <= 1'b1;
                    state  <= REQ;
                end
                REQ: begin
                    // Advance only on the later of the two acks.
                    if (acks_high) begin
                        r_o    <= 1'b0;
                        rctl_o <= 1'b0;
                        state  <= RTZ;
                    end
                end
                RTZ: begin
                    if (acks_low) begin
                        state <= pop ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COND_SINK_SRC_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_pass <= '0;
            cnt_drop <= '0;
        end else if ((state == REQ) && acks_high) begin
            if (dctl_o) begin
                cnt_pass <= cnt_pass + 32'd1;
            end else begin
                cnt_drop <= cnt_drop + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_sink_src.sv
// tb/tb_cond_sink_src.sv - randomized self-checking bench for cond_sink_src with a 4-phase responder model
module tb_cond_sink_src;
    localparam int N     = 8;
    localparam int DEPTH = 2;
    localparam int SYNC  = 2;

    logic         clk     = 1'b0;
    logic         rst     = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_keep  = 1'b0;
    logic [N-1:0] s_data  = '0;
    logic         a_o     = 1'b0;
    logic         actl_o  = 1'b0;
    logic         s_ready;
    logic         r_o;
    logic         rctl_o;
    logic         dctl_o;
    logic [N-1:0] d_o;
`ifdef COND_SINK_SRC_CNT_EN
    logic [31:0]  cnt_pass;
    logic [31:0]  cnt_drop;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [N:0]  exp_q[$];
    int          mode     = 2;
    int          rs       = 0;
    int unsigned m_pass   = 0;
    int unsigned m_drop   = 0;

    always #5 clk = ~clk;

    cond_sink_src #(.N(N), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .r_o     (r_o),
        .a_o     (a_o),
        .d_o     (d_o),
        .rctl_o  (rctl_o),
        .dctl_o  (dctl_o),
        .actl_o  (actl_o)
`ifdef COND_SINK_SRC_CNT_EN
        ,
        .cnt_pass(cnt_pass),
        .cnt_drop(cnt_drop)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic k, input logic [N-1:0] d);
        int i;
        s_valid = 1'b1;
        s_keep  = k;
        s_data  = d;
        for (i = 0; i < 2000 && !s_ready; i++) @(negedge clk);
        if (!s_ready) begin
            check("push_timeout", 64'd0, 64'd1);
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
        exp_q.push_back({k, d});
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && rs == 0 && !a_o && !actl_o && !r_o) break;
        end
        check("drain", 64'(i < 3000), 64'd1);
    endtask

    // Responder: 0 random ack skew, 1 stall acks, 2 fixed skew (data +3, ctl +10)
    initial begin
        int         da = 0;
        int         dc = 0;
        int         cyc = 0;
        int         gap = 0;
        bit         pending = 1'b0;
        logic [N:0] cur = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rs = 0; a_o = 1'b0; actl_o = 1'b0; pending = 1'b0;
                m_pass = 0; m_drop = 0;
                exp_q.delete();
            end else begin
                case (rs)
                    0: begin
                        gap++;
                        if (r_o) begin
                            if (pending) check("rerise_gap", 64'(gap), 64'(SYNC + 2));
                            pending = 1'b0;
                            check("req_pair_rise", 64'(rctl_o), 64'd1);
                            if (exp_q.size() == 0) begin
                                check("unexpected_req", 64'd1, 64'd0);
                            end else begin
                                cur = exp_q.pop_front();
                                check("d_o", 64'(d_o), 64'(cur[N-1:0]));
                                check("dctl_o", 64'(dctl_o), 64'(cur[N]));
                            end
                            if (mode == 2) begin
                                da = 3; dc = 10;
                            end else begin
                                da = $urandom_range(0, 6); dc = $urandom_range(0, 6);
                            end
                            rs = 1;
                        end else if (pending && gap > SYNC + 2) begin
                            check("rerise_gap", 64'(gap), 64'(SYNC + 2));
                            pending = 1'b0;
                        end
                    end
                    1: begin
                        if (mode != 1) begin
                            if (da == 0) a_o = 1'b1; else da--;
                            if (dc == 0) actl_o = 1'b1; else dc--;
                            if (a_o && actl_o) begin
                                cyc = 0;
                                rs  = 2;
                            end
                        end
                    end
                    2: begin
                        cyc++;
                        if (cyc == SYNC) check("req_hold", 64'({r_o, rctl_o}), 64'd3);
                        if (cyc == SYNC + 1) begin
                            check("req_fall", 64'({r_o, rctl_o}), 64'd0);
                            check("d_o_stable", 64'(d_o), 64'(cur[N-1:0]));
                            check("dctl_o_stable", 64'(dctl_o), 64'(cur[N]));
                            if (cur[N]) m_pass++; else m_drop++;
                            da = $urandom_range(0, 6);
                            dc = $urandom_range(0, 6);
                            rs = 3;
                        end
                    end
                    default: begin
                        if (da == 0) a_o = 1'b0; else da--;
                        if (dc == 0) actl_o = 1'b0; else dc--;
                        if (!a_o && !actl_o) begin
                            check("rtz_hold", 64'(r_o), 64'd0);
                            pending = (exp_q.size() != 0);
                            gap = 0;
                            rs  = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        int unsigned base;
        int          i;
        repeat (2) @(negedge clk);
        check("rst_r_o", 64'(r_o), 64'd0);
        check("rst_rctl_o", 64'(rctl_o), 64'd0);
        check("rst_d_o", 64'(d_o), 64'd0);
        check("rst_dctl_o", 64'(dctl_o), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("s_ready_after_rst", 64'(s_ready), 64'd1);

        // Single token latency, then skewed acks (data +3, ctl +10)
        s_valid = 1'b1; s_keep = 1'b1; s_data = 8'h01;
        @(negedge clk);
        s_valid = 1'b0;
        exp_q.push_back({1'b1, 8'h01});
        check("lat_t0_r_o", 64'(r_o), 64'd0);
        @(negedge clk);
        check("lat_t1_d_o", 64'(d_o), 64'h01);
        check("lat_t1_dctl_o", 64'(dctl_o), 64'd1);
        check("lat_t1_r_o", 64'(r_o), 64'd0);
        @(negedge clk);
        check("lat_t2_reqs", 64'({r_o, rctl_o}), 64'd3);
        wait_idle();

        // Full FIFO with stalled acks
        mode = 1;
        base = m_pass + m_drop;
        push(1'b1, 8'h31);
        push(1'b0, 8'h32);
        push(1'b1, 8'h33);
        check("full_s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b1; s_keep = 1'b0; s_data = 8'h34;
        repeat (5) @(negedge clk);
        check("full_hold", 64'(s_ready), 64'd0);
        mode = 0;
        push(1'b0, 8'h34);
        check("accept_after_pop", 64'((m_pass + m_drop - base) >= 1), 64'd1);
        wait_idle();

        // keep pattern 1,0,1,0
        base = m_pass;
        push(1'b1, 8'h0A);
        push(1'b0, 8'h0B);
        push(1'b1, 8'h0C);
        push(1'b0, 8'h0D);
        wait_idle();
        check("pattern_pass_delta", 64'(m_pass - base), 64'd2);
`ifdef COND_SINK_SRC_CNT_EN
        check("cnt_pass", 64'(cnt_pass), 64'(m_pass));
        check("cnt_drop", 64'(cnt_drop), 64'(m_drop));
`endif

        // Reset while in REQ
        mode = 1;
        push(1'b1, 8'h51);
        push(1'b0, 8'h52);
        for (i = 0; i < 50 && !r_o; i++) @(negedge clk);
        check("mid_req_seen", 64'(r_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_reqs", 64'({r_o, rctl_o}), 64'd0);
        check("async_rst_s_ready", 64'(s_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        mode = 0;
        repeat (10) @(negedge clk);
        check("post_rst_no_req", 64'(r_o), 64'd0);
        check("post_rst_s_ready", 64'(s_ready), 64'd1);
`ifdef COND_SINK_SRC_CNT_EN
        check("post_rst_cnt", 64'({cnt_pass, cnt_drop}), 64'd0);
`endif

        // Random back-to-back stream
        for (int k = 0; k < 24; k++) begin
            push(1'($urandom_range(0, 1)), N'($urandom_range(0, 255)));
        end
        wait_idle();
`ifdef COND_SINK_SRC_CNT_EN
        check("final_cnt_pass", 64'(cnt_pass), 64'(m_pass));
        check("final_cnt_drop", 64'(cnt_drop), 64'(m_drop));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
